// File: rtl/seg_monitor.sv
// seg_monitor
//   Receive-side monitor for the 7-segment bus driven by the hex up/down
//   counter. It debounces the segment pattern, decodes stable patterns back
//   to a hex digit and classifies each newly accepted digit as an up step,
//   a down step or a jump. Undecodable patterns are flagged.
//
//   Optional feature macro: SEG_MON_DP_EN
//     defined   : SEG_in[7] (decimal point) is part of the debounce key and
//                 dp follows SEG_in[7] of each accepted pattern.
//     undefined : SEG_in[7] is ignored and dp is tied low.
//
// Ports
//   clk_2        in   1      system clock, rising edge
//   reset        in   1      synchronous, active-high reset
//   SEG_in       in   8      [6:0] segments g..a, [7] decimal point
//   value        out  4      last accepted decoded digit
//   valid        out  1      value holds a decoded digit
//   dir_up       out  1      pulse: accepted digit == previous + 1 (mod 16)
//   dir_down     out  1      pulse: accepted digit == previous - 1 (mod 16)
//   step_err     out  1      pulse: accepted digit is a jump
//   invalid_err  out  1      pulse: accepted pattern is not decodable
//   change_count out  CNT_W  saturating count of dir_up/dir_down/step_err
//   dp           out  1      decimal point of the accepted pattern
//   state_dbg    out  1      debounce FSM state (0 = HUNT, 1 = LOCKED)
//
// There is no valid/ready handshake on this block: SEG_in is sampled every
// cycle, valid only qualifies value, and the four event outputs are
// single-cycle pulses with no back-pressure.

module seg_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [7:0]       SEG_in,
  output logic [3:0]       value,
  output logic             valid,
  output logic             dir_up,
  output logic             dir_down,
  output logic             step_err,
  output logic             invalid_err,
  output logic [CNT_W-1:0] change_count,
  output logic             dp,
  output logic             state_dbg
);

  // run must hold STABLE_CYCLES + 1 so the saturation compare cannot wrap.
  localparam int RUN_W = $clog2(STABLE_CYCLES + 2);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state, next_state;
  logic [7:0]       cand;
  logic [RUN_W-1:0] run, run_next, n;
  logic [7:0]       key;
  logic             same;
  logic             accept;

  logic [4:0]       dec;        // {decodable, digit}
  logic             blank;
  logic [3:0]       value_inc, value_dec;
  logic             up_c, down_c, step_c, inv_c;
  logic             evt_c;

  // 7-segment pattern to hex digit; bit 4 marks a pattern in the table.
  function automatic logic [4:0] decode7(input logic [6:0] p);
    logic [4:0] r;
    r = 5'h00;
    case (p)
      7'h3F: r = 5'h10;
      7'h06: r = 5'h11;
      7'h5B: r = 5'h12;
      7'h4F: r = 5'h13;
      7'h66: r = 5'h14;
      7'h6D: r = 5'h15;
      7'h7D: r = 5'h16;
      7'h07: r = 5'h17;
      7'h7F: r = 5'h18;
      7'h6F: r = 5'h19;
      7'h77: r = 5'h1A;
      7'h7C: r = 5'h1B;
      7'h39: r = 5'h1C;
      7'h5E: r = 5'h1D;
      7'h79: r = 5'h1E;
      7'h71: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

`ifdef SEG_MON_DP_EN
  assign key = SEG_in;
`else
  logic unused_seg_dp;
  assign unused_seg_dp = SEG_in[7];
  assign key = {1'b0, SEG_in[6:0]};
`endif

  // Debounce run length and FSM next state.
  always_comb begin
    same       = (key == cand);
    n          = same ? (run + RUN_W'(1)) : RUN_W'(1);
    run_next   = (n > RUN_MAX) ? RUN_MAX : n;
    next_state = state;
    accept     = 1'b0;
    case (state)
      HUNT: begin
        if (n == RUN_MAX) begin
          accept     = 1'b1;
          next_state = LOCKED;
        end
      end
      LOCKED: begin
        if (!same) begin
          // With a one-sample debounce the new pattern is already stable.
          if (n == RUN_MAX) begin
            accept = 1'b1;
          end else begin
            next_state = HUNT;
          end
        end
      end
      default: next_state = HUNT;
    endcase
  end

  // Classification of the pattern being accepted this cycle.
  always_comb begin
    dec       = decode7(key[6:0]);
    blank     = (key[6:0] == 7'h00);
    value_inc = value + 4'd1;
    value_dec = value - 4'd1;
    up_c      = 1'b0;
    down_c    = 1'b0;
    step_c    = 1'b0;
    inv_c     = 1'b0;
    if (accept && !blank) begin
      if (!dec[4]) begin
        inv_c = 1'b1;
      end else if (valid) begin
        if (dec[3:0] == value_inc) begin
          up_c = 1'b1;
        end else if (dec[3:0] == value_dec) begin
          down_c = 1'b1;
        end else if (dec[3:0] != value) begin
          step_c = 1'b1;
        end
      end
    end
    evt_c = up_c | down_c | step_c;
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state        <= HUNT;
      cand         <= 8'h00;
      run          <= '0;
      value        <= 4'h0;
      valid        <= 1'b0;
      dir_up       <= 1'b0;
      dir_down     <= 1'b0;
      step_err     <= 1'b0;
      invalid_err  <= 1'b0;
      change_count <= '0;
    end else begin
      state       <= next_state;
      cand        <= key;
      run         <= run_next;
      dir_up      <= up_c;
      dir_down    <= down_c;
      step_err    <= step_c;
      invalid_err <= inv_c;
      if (accept) begin
        if (blank || !dec[4]) begin
          valid <= 1'b0;
        end else begin
          value <= dec[3:0];
          valid <= 1'b1;
        end
      end
      if (evt_c && (change_count != {CNT_W{1'b1}})) begin
        change_count <= change_count + CNT_W'(1);
      end
    end
  end

`ifdef SEG_MON_DP_EN
  always_ff @(posedge clk_2) begin
    if (reset) begin
      dp <= 1'b0;
    end else if (accept) begin
      dp <= key[7];
    end
  end
`else
  assign dp = 1'b0;
`endif

  assign state_dbg = state;

endmodule
